// File: rtl/ctrl_pipe_if.sv
// rtl/ctrl_pipe_if.sv - decode/execute boundary bundle for ctrl_pipe
// CTRL_PERF_CNT_EN adds the stall_cnt/taken_cnt performance counters.
interface ctrl_pipe_if #(
    parameter int OPW = 3,
    parameter int RW  = 3,
    parameter int DW  = 8
`ifdef CTRL_PERF_CNT_EN
    , parameter int CW = 16
`endif
);
    localparam int IW = OPW + 2 * RW;
    localparam int JW = IW - OPW - 1;

    logic [IW-1:0]  mach_code;
    logic           instr_valid;
    logic           gt;
    logic           eq;

    logic [OPW-1:0] Aluop;
    logic [1:0]     mode;
    logic           bmode;
    logic [JW-1:0]  Jptr;
    logic [RW-1:0]  Ra;
    logic [RW-1:0]  Rb;
    logic [DW-1:0]  Imm;
    logic           WenR;
    logic           WenD;
    logic           Jen;
    logic           ImmToReg;
    logic           MemToReg;
    logic           Load;
    logic           Store;
    logic           Done;
    logic           Stall;
    logic           Flush;

`ifdef CTRL_PERF_CNT_EN
    logic [CW-1:0]  stall_cnt;
    logic [CW-1:0]  taken_cnt;

    modport slave (
        input  mach_code, instr_valid, gt, eq,
        output Aluop, mode, bmode, Jptr, Ra, Rb, Imm,
               WenR, WenD, Jen, ImmToReg, MemToReg, Load, Store,
               Done, Stall, Flush, stall_cnt, taken_cnt
    );
    modport master (
        output mach_code, instr_valid, gt, eq,
        input  Aluop, mode, bmode, Jptr, Ra, Rb, Imm,
               WenR, WenD, Jen, ImmToReg, MemToReg, Load, Store,
               Done, Stall, Flush, stall_cnt, taken_cnt
    );
`else
    modport slave (
        input  mach_code, instr_valid, gt, eq,
        output Aluop, mode, bmode, Jptr, Ra, Rb, Imm,
               WenR, WenD, Jen, ImmToReg, MemToReg, Load, Store,
               Done, Stall, Flush
    );
    modport master (
        output mach_code, instr_valid, gt, eq,
        input  Aluop, mode, bmode, Jptr, Ra, Rb, Imm,
               WenR, WenD, Jen, ImmToReg, MemToReg, Load, Store,
               Done, Stall, Flush
    );
`endif
endinterface

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - registered instruction decoder with flag forwarding, load-use stall and branch flush
// CTRL_PERF_CNT_EN adds saturating stall/taken-branch counters.
module ctrl_pipe #(
    parameter int OPW = 3,
    parameter int RW  = 3,
    parameter int DW  = 8
`ifdef CTRL_PERF_CNT_EN
    , parameter int CW = 16
`endif
) (
    input  logic        Clk,
    input  logic        Reset_n,
    ctrl_pipe_if.slave  bus
);
    localparam int IW = OPW + 2 * RW;
    localparam int JW = IW - OPW - 1;

    localparam logic [OPW-1:0] OP_ADD    = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB    = OPW'(1);
    localparam logic [OPW-1:0] OP_DONE   = OPW'(2);
    localparam logic [OPW-1:0] OP_LOAD   = OPW'(3);
    localparam logic [OPW-1:0] OP_STORE  = OPW'(4);
    localparam logic [OPW-1:0] OP_SHIFT  = OPW'(5);
    localparam logic [OPW-1:0] OP_BRANCH = OPW'(6);
    localparam logic [OPW-1:0] OP_MOV    = OPW'(7);

    typedef struct packed {
        logic [OPW-1:0] aluop;
        logic [1:0]     mode;
        logic           bmode;
        logic [JW-1:0]  jptr;
        logic [RW-1:0]  ra;
        logic [RW-1:0]  rb;
        logic [DW-1:0]  imm;
        logic           wen_r;
        logic           wen_d;
        logic           jen;
        logic           imm_to_reg;
        logic           mem_to_reg;
        logic           load;
        logic           store;
    } ctrl_t;

    ctrl_t          ex_q;
    ctrl_t          dec_d;
    logic           done_q;
    logic           done_d;
    logic           fgt_q;
    logic           feq_q;

    logic [OPW-1:0] op;
    logic [RW-1:0]  ra_f;
    logic [RW-1:0]  rb_f;
    logic           bmode_f;
    logic           ex_sets_flags;
    logic           hazard_op;
    logic           cond;
    logic           stall;
    logic           flush;
    logic           bubble;

    assign op      = bus.mach_code[IW-1 -: OPW];
    assign ra_f    = bus.mach_code[2*RW-1:RW];
    assign rb_f    = bus.mach_code[RW-1:0];
    assign bmode_f = bus.mach_code[JW];

    // The op sitting in EX drives gt/eq this cycle; when it is a flag-setter
    // the branch must see those live values rather than the stale register.
    assign ex_sets_flags = ex_q.wen_r &&
                           (ex_q.aluop == OP_ADD || ex_q.aluop == OP_SUB || ex_q.aluop == OP_SHIFT);

    assign cond = ex_sets_flags ? (bmode_f ? bus.eq : bus.gt)
                                : (bmode_f ? feq_q  : fgt_q);

    assign hazard_op = (op == OP_ADD)  || (op == OP_SUB)   || (op == OP_LOAD) ||
                       (op == OP_STORE) || (op == OP_SHIFT);

    assign flush  = ex_q.jen;
    assign stall  = ex_q.load && bus.instr_valid && hazard_op &&
                    ((ra_f == ex_q.ra) || (rb_f == ex_q.ra)) && !flush;
    assign bubble = !bus.instr_valid || stall || flush || (done_q && (op != OP_DONE));

    always_comb begin
        dec_d  = '0;
        done_d = done_q;
        if (!bubble) begin
            dec_d.aluop = op;
            case (op)
                OP_ADD, OP_SUB: begin
                    dec_d.ra    = ra_f;
                    dec_d.rb    = rb_f;
                    dec_d.wen_r = 1'b1;
                end
                OP_LOAD: begin
                    dec_d.ra         = ra_f;
                    dec_d.rb         = rb_f;
                    dec_d.wen_r      = 1'b1;
                    dec_d.mem_to_reg = 1'b1;
                    dec_d.load       = 1'b1;
                end
                OP_STORE: begin
                    dec_d.ra    = ra_f;
                    dec_d.rb    = rb_f;
                    dec_d.wen_d = 1'b1;
                    dec_d.store = 1'b1;
                end
                OP_SHIFT: begin
                    dec_d.mode  = bus.mach_code[IW-OPW-1 -: 2];
                    dec_d.ra    = rb_f;
                    dec_d.rb    = rb_f;
                    dec_d.wen_r = 1'b1;
                end
                OP_BRANCH: begin
                    dec_d.bmode = bmode_f;
                    dec_d.jptr  = bus.mach_code[JW-1:0];
                    dec_d.jen   = cond;
                end
                OP_MOV: begin
                    dec_d.ra         = ra_f;
                    dec_d.rb         = rb_f;
                    dec_d.imm        = DW'(rb_f);
                    dec_d.wen_r      = 1'b1;
                    dec_d.imm_to_reg = 1'b1;
                end
                OP_DONE: begin
                    done_d = !bus.mach_code[0];
                end
                default: begin
                    dec_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ex_q   <= '0;
            done_q <= 1'b0;
            fgt_q  <= 1'b0;
            feq_q  <= 1'b0;
        end else begin
            ex_q   <= dec_d;
            done_q <= done_d;
            if (ex_sets_flags) begin
                fgt_q <= bus.gt;
                feq_q <= bus.eq;
            end
        end
    end

    assign bus.Aluop    = ex_q.aluop;
    assign bus.mode     = ex_q.mode;
    assign bus.bmode    = ex_q.bmode;
    assign bus.Jptr     = ex_q.jptr;
    assign bus.Ra       = ex_q.ra;
    assign bus.Rb       = ex_q.rb;
    assign bus.Imm      = ex_q.imm;
    assign bus.WenR     = ex_q.wen_r;
    assign bus.WenD     = ex_q.wen_d;
    assign bus.Jen      = ex_q.jen;
    assign bus.ImmToReg = ex_q.imm_to_reg;
    assign bus.MemToReg = ex_q.mem_to_reg;
    assign bus.Load     = ex_q.load;
    assign bus.Store    = ex_q.store;
    assign bus.Done     = done_q;
    assign bus.Stall    = stall;
    assign bus.Flush    = flush;

`ifdef CTRL_PERF_CNT_EN
    logic [CW-1:0] stall_cnt_q;
    logic [CW-1:0] taken_cnt_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stall_cnt_q <= '0;
            taken_cnt_q <= '0;
        end else begin
            if (stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CW'(1);
            if (ex_q.jen && !(&taken_cnt_q)) taken_cnt_q <= taken_cnt_q + CW'(1);
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.taken_cnt = taken_cnt_q;
`endif
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - directed and random checks of ctrl_pipe against a behavioural decode model
module tb_ctrl_pipe;
    logic Clk;
    logic Reset_n;

`ifdef CTRL_PERF_CNT_EN
    localparam int CW = 16;
    ctrl_pipe_if #(.OPW(3), .RW(3), .DW(8), .CW(CW)) bus ();
    ctrl_pipe #(.OPW(3), .RW(3), .DW(8), .CW(CW)) u_dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));
`else
    ctrl_pipe_if #(.OPW(3), .RW(3), .DW(8)) bus ();
    ctrl_pipe #(.OPW(3), .RW(3), .DW(8)) u_dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));
`endif

    typedef struct packed {
        logic [2:0] aluop;
        logic [1:0] mode;
        logic       bmode;
        logic [4:0] jptr;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] imm;
        logic       wen_r;
        logic       wen_d;
        logic       jen;
        logic       imm_to_reg;
        logic       mem_to_reg;
        logic       load;
        logic       store;
        logic       done;
    } obs_t;

    obs_t m;
    logic m_fgt;
    logic m_feq;
    int   n_vec;
    int   n_bad;
`ifdef CTRL_PERF_CNT_EN
    int   m_stall_cnt;
    int   m_taken_cnt;
`endif

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic obs_t dut_obs();
        return {bus.Aluop, bus.mode, bus.bmode, bus.Jptr, bus.Ra, bus.Rb, bus.Imm,
                bus.WenR, bus.WenD, bus.Jen, bus.ImmToReg, bus.MemToReg,
                bus.Load, bus.Store, bus.Done};
    endfunction

    task automatic model_reset();
        m     = '0;
        m_fgt = 1'b0;
        m_feq = 1'b0;
`ifdef CTRL_PERF_CNT_EN
        m_stall_cnt = 0;
        m_taken_cnt = 0;
`endif
    endtask

    // What the decode stage should register for one presented instruction.
    task automatic model_next(input logic [8:0] mc, input logic iv, input logic g, input logic e,
                              output obs_t n, output logic st);
        logic [2:0] op;
        logic [2:0] a;
        logic [2:0] b;
        logic       fwd;
        logic       sel_gt;
        logic       sel_eq;
        op = mc[8:6];
        a  = mc[5:3];
        b  = mc[2:0];
        st = m.load && iv && (op inside {3'd0, 3'd1, 3'd3, 3'd4, 3'd5}) &&
             (a == m.ra || b == m.ra) && !m.jen;
        fwd    = m.wen_r && (m.aluop inside {3'd0, 3'd1, 3'd5});
        sel_gt = fwd ? g : m_fgt;
        sel_eq = fwd ? e : m_feq;
        n      = '0;
        n.done = m.done;
        if (iv && !st && !m.jen && !(m.done && op != 3'd2)) begin
            n.aluop = op;
            case (op)
                3'd0, 3'd1: begin n.ra = a; n.rb = b; n.wen_r = 1'b1; end
                3'd2:       n.done = ~mc[0];
                3'd3:       begin n.ra = a; n.rb = b; n.wen_r = 1'b1; n.mem_to_reg = 1'b1; n.load = 1'b1; end
                3'd4:       begin n.ra = a; n.rb = b; n.wen_d = 1'b1; n.store = 1'b1; end
                3'd5:       begin n.mode = mc[5:4]; n.ra = b; n.rb = b; n.wen_r = 1'b1; end
                3'd6:       begin n.bmode = mc[5]; n.jptr = mc[4:0]; n.jen = mc[5] ? sel_eq : sel_gt; end
                default:    begin n.ra = a; n.rb = b; n.imm = {5'b0, b}; n.wen_r = 1'b1; n.imm_to_reg = 1'b1; end
            endcase
        end
        if (fwd) begin
            m_fgt = g;
            m_feq = e;
        end
    endtask

    // Called at a negedge; drives one cycle and returns at the following negedge.
    task automatic step(input logic [8:0] mc, input logic iv, input logic g, input logic e);
        obs_t n;
        logic st;
        bus.mach_code   = mc;
        bus.instr_valid = iv;
        bus.gt          = g;
        bus.eq          = e;
        #1;
        check("flush", {63'b0, bus.Flush}, {63'b0, m.jen});
        model_next(mc, iv, g, e, n, st);
        check("stall", {63'b0, bus.Stall}, {63'b0, st});
`ifdef CTRL_PERF_CNT_EN
        if (st && m_stall_cnt < (2**CW - 1)) m_stall_cnt++;
        if (m.jen && m_taken_cnt < (2**CW - 1)) m_taken_cnt++;
`endif
        @(posedge Clk);
        m = n;
        @(negedge Clk);
        check("regs", 64'(dut_obs()), 64'(m));
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        model_reset();
        Reset_n         = 1'b0;
        bus.mach_code   = '0;
        bus.instr_valid = 1'b1;
        bus.gt          = 1'b0;
        bus.eq          = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            bus.mach_code = 9'($urandom);
            bus.gt        = 1'($urandom);
            bus.eq        = 1'($urandom);
            #1;
            check("reset_regs", 64'(dut_obs()), 64'd0);
            check("reset_stall_flush", {62'b0, bus.Stall, bus.Flush}, 64'd0);
        end
        @(negedge Clk);
        Reset_n = 1'b1;

        step(9'b111_010_101, 1'b1, 1'b0, 1'b0);
        check("mov_ra", 64'(bus.Ra), 64'd2);
        check("mov_rb", 64'(bus.Rb), 64'd5);
        check("mov_imm", 64'(bus.Imm), 64'h05);
        check("mov_en", {62'b0, bus.WenR, bus.ImmToReg}, 64'd3);
        step(9'd0, 1'b0, 1'b0, 1'b0);

        step(9'b011_001_010, 1'b1, 1'b0, 1'b0);
        step(9'b000_001_011, 1'b1, 1'b0, 1'b0);
        check("lu_bubble", {60'b0, bus.Aluop, bus.WenR}, 64'd0);
        step(9'b000_001_011, 1'b1, 1'b0, 1'b0);
        check("lu_add_ra_rb", {58'b0, bus.Ra, bus.Rb}, {58'b0, 3'd1, 3'd3});
        check("lu_add_wen", 64'(bus.WenR), 64'd1);

        step(9'b000_001_010, 1'b1, 1'b0, 1'b0);
        step(9'b110_0_00111, 1'b1, 1'b1, 1'b0);
        check("fwd_jen_flush", {62'b0, bus.Jen, bus.Flush}, 64'd3);
        check("fwd_jptr", 64'(bus.Jptr), 64'd7);
        step(9'b000_010_011, 1'b1, 1'b0, 1'b0);
        check("fwd_squash", {60'b0, bus.Aluop, bus.WenR}, 64'd0);
        step(9'd0, 1'b0, 1'b0, 1'b0);

        step(9'b101_010_011, 1'b1, 1'b0, 1'b0);
        step(9'b011_110_110, 1'b1, 1'b0, 1'b1);
        step(9'b110_1_00100, 1'b1, 1'b0, 1'b0);
        check("hold_jen", 64'(bus.Jen), 64'd1);
        check("hold_jptr", 64'(bus.Jptr), 64'd4);
        step(9'd0, 1'b0, 1'b0, 1'b0);

        step(9'b010_000_000, 1'b1, 1'b0, 1'b0);
        check("done_set", 64'(bus.Done), 64'd1);
        step(9'b000_001_010, 1'b1, 1'b0, 1'b0);
        check("done_bubble", {61'b0, bus.WenR, bus.Done, bus.Aluop[0]}, {61'b0, 3'b010});
        step(9'b010_000_001, 1'b1, 1'b0, 1'b0);
        check("done_clear", 64'(bus.Done), 64'd0);
        step(9'b000_001_010, 1'b1, 1'b0, 1'b0);
        check("done_resume", 64'(bus.WenR), 64'd1);

        for (int i = 0; i < 3000; i++) begin
            step(9'($urandom), ($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom));
        end

`ifdef CTRL_PERF_CNT_EN
        check("stall_cnt", 64'(bus.stall_cnt), 64'(m_stall_cnt));
        check("taken_cnt", 64'(bus.taken_cnt), 64'(m_taken_cnt));
`endif

        step(9'd0, 1'b0, 1'b0, 1'b0);
        step(9'b011_001_010, 1'b1, 1'b0, 1'b0);
        bus.mach_code   = 9'b000_001_011;
        bus.instr_valid = 1'b1;
        #1;
        check("mid_stall_pre", 64'(bus.Stall), 64'd1);
        Reset_n = 1'b0;
        #1;
        check("mid_stall_rst", {62'b0, bus.Stall, bus.Flush}, 64'd0);
        check("mid_stall_regs", 64'(dut_obs()), 64'd0);
        @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();

        step(9'b000_001_010, 1'b1, 1'b0, 1'b0);
        step(9'b110_0_00011, 1'b1, 1'b1, 1'b0);
        #1;
        check("mid_flush_pre", 64'(bus.Flush), 64'd1);
        Reset_n = 1'b0;
        #1;
        check("mid_flush_rst", {62'b0, bus.Stall, bus.Flush}, 64'd0);
        @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
        step(9'b111_011_001, 1'b1, 1'b0, 1'b0);
        step(9'd0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
